// File: rtl/ma_rw_pipe_reg_if.sv
// MA -> RW pipeline register bus.
// Payload, valid/ready handshakes, flush and status.
interface ma_rw_pipe_reg_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int IR_W   = 32,
  parameter int CTRL_W = 22,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_ld;
  logic [IR_W-1:0]   in_ir;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_ld;
  logic [IR_W-1:0]   out_ir;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_pc, in_alu,
    output in_ld, in_ir, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc,
    input  out_alu, out_ld, out_ir, out_ctrl,
    input  occupancy, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_pc, in_alu,
    input  in_ld, in_ir, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc,
    output out_alu, out_ld, out_ir, out_ctrl,
    output occupancy, stall_cnt
  );
endinterface

// File: rtl/ma_rw_pipe_reg.sv
// MA/RW pipeline register: 2-entry skid buffer,
// registered ready, flush and saturating stall counter.
module ma_rw_pipe_reg #(
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 32,
  parameter int              IR_W     = 32,
  parameter int              CTRL_W   = 22,
  parameter logic [IR_W-1:0] NOP_IR   = '0,
  parameter bit              NEG_EDGE = 1'b1,
  parameter int              CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  ma_rw_pipe_reg_if.slave  bus
);
  localparam int W = PC_W + 2 * DATA_W + IR_W + CTRL_W;
  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic             aclk;
  logic [W-1:0]     in_word;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             rdy_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire, out_fire;

  logic [PC_W-1:0]   m_pc;
  logic [DATA_W-1:0] m_alu, m_ld;
  logic [IR_W-1:0]   m_ir;
  logic [CTRL_W-1:0] m_ctrl;

  // Edge select folded into the clock so one register set serves both.
  assign aclk = NEG_EDGE ? ~clk : clk;

  assign in_word  = {bus.in_pc, bus.in_alu, bus.in_ld,
                     bus.in_ir, bus.in_ctrl};
  assign in_fire  = bus.in_valid & rdy_q;
  assign out_fire = main_v_q & bus.out_ready;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_fire) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = in_fire;
        if (in_fire) skid_d = in_word;
      end else begin
        main_v_d = in_fire;
        if (in_fire) main_d = in_word;
      end
    end else if (in_fire) begin
      skid_d   = in_word;
      skid_v_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_v_q && !bus.out_ready && !(&stall_q))
      stall_d = stall_q + ONE;
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      stall_q  <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
      stall_q  <= stall_d;
    end
  end

  assign {m_pc, m_alu, m_ld, m_ir, m_ctrl} = main_q;

  // Bubble: zero payload so RW can never write a register.
  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = main_v_q;
  assign bus.out_pc    = main_v_q ? m_pc : '0;
  assign bus.out_alu   = main_v_q ? m_alu : '0;
  assign bus.out_ld    = main_v_q ? m_ld : '0;
  assign bus.out_ir    = main_v_q ? m_ir : NOP_IR;
  assign bus.out_ctrl  = main_v_q ? m_ctrl : '0;
  assign bus.occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign bus.stall_cnt = stall_q;
endmodule

// File: doc/ma_rw_pipe_reg.md
# ma_rw_pipe_reg

Parametrised, handshaked pipeline register between the memory-access (MA) and register-write (RW) stages. It is the successor of the fixed-width MA/RW latch. It carries PC, ALU result, load result, IR and control bus with valid/ready flow control. A 2-entry skid buffer gives full throughput with a registered ready, and a flush input squashes in-flight instructions. Downstream sees a NOP with zeroed control whenever no valid instruction is held.

## Interface
Parameters:
- PC_W, 32, PC field width
- DATA_W, 32, ALU-result and load-result width
- IR_W, 32, instruction register width
- CTRL_W, 22, control bus width
- NOP_IR, 0, IR value presented when out_valid=0
- NEG_EDGE, 1, 1: state updates on falling edge of clk; 0: rising edge
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  stage clock; single clock domain
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  squash all held entries at the next active edge
- in_valid  in  1  MA presents an instruction
- in_ready  out  1  block can accept; registered, equals !skid_valid
- in_pc / in_alu / in_ld / in_ir / in_ctrl  in  PC_W / DATA_W / DATA_W / IR_W / CTRL_W  MA payload
- out_valid  out  1  RW payload valid
- out_ready  in  1  RW accepts
- out_pc / out_alu / out_ld / out_ir / out_ctrl  out  same widths  RW payload
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  count of edges with out_valid=1 and out_ready=0; saturates at all-ones

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry has a valid bit.
- Input handshake: in_fire = in_valid & in_ready. Output handshake: out_fire = out_valid & out_ready.
- Per active edge, when no flush:
  - Main empty or out_fire, skid empty: main <= input if in_fire, else main invalid.
  - Main empty or out_fire, skid full: main <= skid, skid <= input if in_fire, else skid invalid.
  - Main full, no out_fire, in_fire: skid <= input. This is only possible while skid is empty.
- Order is strict FIFO; no entry is dropped or duplicated.
- in_ready is registered. It is 0 exactly while the skid entry holds data.
- flush: both valid bits cleared and input on the same edge discarded, whether or not in_fire. in_ready=1 after the edge.
- reset has priority over flush, and flush over all data movement.
- Bubble: when out_valid=0, out_ir=NOP_IR, out_ctrl=0, and out_pc/out_alu/out_ld=0. No register write can occur downstream.
- occupancy = main_valid + skid_valid.
- stall_cnt increments once per edge with out_valid & !out_ready. It holds at 2^CNT_W-1 and clears only on reset. flush does not clear it.

## Timing
- Active edge: negedge clk if NEG_EDGE=1, else posedge. reset acts asynchronously on either setting.
- Reset values:
  - out_valid=0, in_ready=1, occupancy=0, stall_cnt=0
  - out_pc=0, out_alu=0, out_ld=0, out_ir=NOP_IR, out_ctrl=0
- Latency: input accepted at edge N appears on outputs after edge N when the buffer is empty (1 edge).
- Throughput: 1 transfer/edge sustained with out_ready=1.
- Backpressure: after out_ready falls, at most one further input is accepted, into skid. in_ready drops after that edge.
- Release: with both entries full, out_ready=1 drains the skid to main in 1 edge. in_ready returns to 1 after that edge.
- Reset asserted mid-transfer: outputs take reset values immediately, without waiting for an edge. First acceptance is at the first active edge after deassertion.

## Test plan
- Reset with in_ir=32'hDEADBEEF, in_ctrl=22'h3FFFFF held -> out_valid=0, out_ir=NOP_IR, out_ctrl=0, in_ready=1, occupancy=0.
- Stream PC 0x00,0x04,0x08,0x0C with out_ready=1 -> each appears 1 edge later in order, out_valid held 1, occupancy=1, stall_cnt=0.
- Stream 0x10,0x14,0x18; drop out_ready after first accept -> 0x14 lands in skid, in_ready=0, occupancy=2, 0x18 held at input. Raise out_ready -> outputs 0x10,0x14,0x18 in order with no loss. stall_cnt equals the number of stalled edges.
- occupancy=2 with flush=1 and in_valid=1 (PC 0x20) on the same edge -> occupancy=0, out_valid=0, out_ctrl=0, 0x20 not delivered, in_ready=1.
- CNT_W=3, out_ready=0 for 10 edges with out_valid=1 -> stall_cnt=7, held.
- Assert reset asynchronously between edges with occupancy=2 -> outputs reach reset values before the next edge. Both NEG_EDGE=0 and 1 are checked.
